uart_tx_tick: RTL and testbench

//   UART transmitter paced by an external one-cycle baud tick (period = cnt+1 clk cycles).

---
 rtl/uart_tx_tick.sv | 123 ++++++++++++
 tb/tb_uart_tx_tick.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_tick.sv
`timescale 1ns/1ps
// uart_tx_tick: UART transmitter paced by an external one-cycle baud strobe.
// Frame on tx: start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop bits (1).
// Each bit lasts exactly one baud_tick interval; the start bit is aligned to the
// first tick after the byte is accepted (a tick in the accept cycle is ignored).
module uart_tx_tick #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q,       tx_d;
    logic                 accept;

    // Ready/busy decode straight from the state so ready rises the cycle IDLE is entered.
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign accept   = tx_valid & tx_ready;

    // Next-state, shift register, counters and next serial bit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;

        case (state_q)
            IDLE: begin
                // Ticks are ignored here, so a tick coinciding with the accept is not used.
                tx_d = 1'b1;
                if (accept) begin
                    shift_d = tx_data;
                    state_d = ARM;
                end
            end
            ARM: begin
                // Wait for a tick so the start bit begins on a bit boundary.
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset forces the line high immediately and discards any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_tick.sv
`timescale 1ns/1ps
// Bench for uart_tx_tick: directed steps, expected frames queued at handshake and
// compared bit by bit as they appear on tx.
module tb_uart_tx_tick;

    localparam int FRAME_LEN = 10;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    logic       baud_tick2;
    logic       tx_valid2;
    logic [7:0] tx_data2;
    logic       tx_ready2;
    logic       tx2;
    logic       busy2;

    int total;
    int bad;

    logic [FRAME_LEN-1:0] exp_q[$];

    int   tick_mode;   // 0: free-running, period 4 clks; 2: driven by tick_man
    logic tick_man;
    logic tick_seen;   // baud_tick as sampled at the last rising edge

    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy)
    );

    uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick2),
        .tx_valid  (tx_valid2),
        .tx_data   (tx_data2),
        .tx_ready  (tx_ready2),
        .tx        (tx2),
        .busy      (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick source, updated just after each falling edge.
    initial begin
        int tcnt;
        tcnt      = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            tcnt = (tcnt == 3) ? 0 : tcnt + 1;
            if (tick_mode == 0) baud_tick = (tcnt == 3);
            else                baud_tick = tick_man;
        end
    end

    initial begin
        tick_seen = 1'b0;
        forever begin
            @(posedge clk);
            tick_seen = baud_tick;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Offer a byte; returns how many cycles it was held off before acceptance.
    task automatic send(input logic [7:0] b, input bit keep, output int waited);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", tx_ready, 1'b1);
        exp_q.push_back({1'b1, b, 1'b0});
        @(posedge clk);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_tx_idle", tx, 1'b1);
        waited = n;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", tx_ready, 1'b1);
    endtask

    // Scoreboard: each tick boundary starts a new bit; between ticks tx must hold.
    initial begin
        logic [FRAME_LEN-1:0] cur;
        int   bit_idx;
        bit   in_frame;
        logic last_tx;
        cur      = '0;
        bit_idx  = 0;
        in_frame = 1'b0;
        last_tx  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_frame = 1'b0;
            end else if (tick_seen === 1'b1) begin
                if (!in_frame && tx === 1'b0 && exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    bit_idx  = 1;
                    in_frame = 1'b1;
                end else if (!in_frame) begin
                    chk("idle_tx", tx, 1'b1);
                end else begin
                    chk("frame_bit", tx, cur[bit_idx]);
                    bit_idx++;
                    if (bit_idx == FRAME_LEN) in_frame = 1'b0;
                end
            end else begin
                chk("bit_hold", tx, last_tx);
            end
            last_tx = tx;
        end
    end

    initial begin
        int          n;
        logic        lat_ok;
        logic [10:0] exp2;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_valid2  = 1'b0;
        tx_data2   = 8'h00;
        baud_tick2 = 1'b1;
        tick_mode  = 0;
        tick_man   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Tick stuck high, two stop bits, 0x81: one bit per clk
        tx_data2  = 8'h81;
        tx_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid2 = 1'b0;
        chk("t5_arm_tx", tx2, 1'b1);
        chk("t5_arm_busy", busy2, 1'b1);
        exp2 = {2'b11, 8'h81, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("t5_bit", tx2, exp2[i]);
        end
        chk("t5_stop_busy", busy2, 1'b1);
        @(negedge clk);
        chk("t5_done_ready", tx_ready2, 1'b1);

        // Single frame 0xA5 at tick period 4
        send(8'hA5, 1'b0, n);
        wait_idle(n);
        lat_ok = (n >= 41 && n <= 44);
        chk("t2_latency", lat_ok, 1'b1);

        // Back-to-back with tx_valid held high
        send(8'h00, 1'b1, n);
        send(8'hFF, 1'b0, n);
        lat_ok = (n >= 41 && n <= 44);
        chk("t3_b2b_latency", lat_ok, 1'b1);
        wait_idle(n);

        // Offer during a frame is held off; tx_data noise mid-frame is harmless
        send(8'h5A, 1'b0, n);
        repeat (12) begin
            @(negedge clk);
            tx_data = 8'($urandom);
        end
        chk("t4_held_off", tx_ready, 1'b0);
        send(8'h3C, 1'b0, n);
        repeat (20) begin
            @(negedge clk);
            tx_data = 8'($urandom);
        end
        wait_idle(n);

        // Reset in the middle of the data bits
        send(8'h00, 1'b0, n);
        repeat (20) @(negedge clk);
        chk("t1_pre_tx", tx, 1'b0);
        chk("t1_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t1_async_tx", tx, 1'b1);
        chk("t1_async_busy", busy, 1'b0);
        chk("t1_async_ready", tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t1_post_tx", tx, 1'b1);
        chk("t1_post_busy", busy, 1'b0);
        chk("t1_post_ready", tx_ready, 1'b1);

        // Tick in the accept cycle is unused; ticks held low freeze the FSM
        tick_mode = 2;
        tick_man  = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_ready", tx_ready, 1'b1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick_man = 1'b1;
        exp_q.push_back({1'b1, 8'hC3, 1'b0});
        @(negedge clk);
        tx_valid = 1'b0;
        tick_man = 1'b0;
        chk("t6_tick_unused_tx", tx, 1'b1);
        chk("t6_tick_unused_busy", busy, 1'b1);
        repeat (6) @(negedge clk);
        chk("t6_stuck_low_tx", tx, 1'b1);
        chk("t6_stuck_low_busy", busy, 1'b1);
        for (int k = 0; k < 11; k++) begin
            tick_man = 1'b1;
            @(negedge clk);
            tick_man = 1'b0;
            repeat (1 + k % 3) @(negedge clk);
            if (k == 9) chk("t6_not_ready", tx_ready, 1'b0);
        end
        chk("t6_ready_after", tx_ready, 1'b1);
        tick_mode = 0;

        // Every queued frame must have been seen
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
